// File: rtl/tb04_out_sched.sv
// tb04_out_sched: paces CPU and debug bytes onto a UART nibble port.
// Ports:
//   tb04_clk, rst (async, active-high)
//   cpu_wo/cpu_nib       : CPU nibble writes, high nibble first
//   dbg_valid/dbg_byte   : debug byte source, dbg_ready accepts
//   uart_busy            : async UART busy flag (synchronized inside)
//   wo/out_nib           : one-cycle nibble write to the UART
//   cpu_full/cpu_ovf     : CPU FIFO full and sticky drop flag
//   gnt_dbg              : byte in flight came from the debug source
module tb04_out_sched #(
    parameter int GAP_CYC    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       tb04_clk,
    input  logic       rst,
    input  logic       cpu_wo,
    input  logic [3:0] cpu_nib,
    input  logic       dbg_valid,
    input  logic [7:0] dbg_byte,
    output logic       dbg_ready,
    input  logic       uart_busy,
    output logic       wo,
    output logic [3:0] out_nib,
    output logic       cpu_full,
    output logic       cpu_ovf,
    output logic       gnt_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(GAP_CYC) + 1;
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
    localparam logic [1:0] DRAIN_LD = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
        $error("GAP_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_GAP,
        S_LO,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic            busy_m_q, busy_s_q;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   fifo_cnt;
    logic [AW-1:0]   rd_idx0, rd_idx1;
    logic [7:0]      cpu_byte;
    logic [7:0]      byte_q, byte_d;
    logic [CW-1:0]   pace_q, pace_d, pace_dec;
    logic [1:0]      drain_q, drain_d;
    logic            wo_q, wo_d;
    logic [3:0]      out_nib_q, out_nib_d;
    logic            dbg_ready_q, dbg_ready_d;
    logic            gnt_dbg_q, gnt_dbg_d;
    logic            ovf_q, ovf_d;
    logic            last_dbg_q, last_dbg_d;
    logic            push;
    logic            cpu_elig;
    logic            arb_ok;
    logic            take_dbg, take_cpu;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign cpu_full = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign fifo_cnt = wr_q - rd_q;

    // Full is judged on current pointers, so a pop in the same
    // cycle never makes room for the push.
    assign push     = cpu_wo && !cpu_full;
    assign cpu_elig = fifo_cnt >= PW'(2);

    assign rd_idx0  = rd_q[AW-1:0];
    assign rd_idx1  = rd_q[AW-1:0] + AW'(1);
    assign cpu_byte = {mem_q[rd_idx0], mem_q[rd_idx1]};

    assign arb_ok = (state_q == S_IDLE) && (pace_q == '0) && !busy_s_q;

    // last_dbg_q set: debug wins the next contested grant. It is set
    // after a CPU grant and cleared after a debug grant, so out of
    // reset the CPU takes the first contest.
    assign take_dbg = arb_ok && dbg_valid && (!cpu_elig || last_dbg_q);
    assign take_cpu = arb_ok && cpu_elig && !take_dbg;

    assign pace_dec = (pace_q != '0) ? pace_q - CW'(1) : '0;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q + PW'(push);
        rd_d        = rd_q;
        byte_d      = byte_q;
        pace_d      = pace_dec;
        drain_d     = (drain_q != 2'd0) ? drain_q - 2'd1 : 2'd0;
        wo_d        = 1'b0;
        out_nib_d   = out_nib_q;
        dbg_ready_d = 1'b0;
        gnt_dbg_d   = gnt_dbg_q;
        ovf_d       = ovf_q | (cpu_wo & cpu_full);
        last_dbg_d  = last_dbg_q;
        unique case (state_q)
            S_IDLE: begin
                if (take_dbg) begin
                    state_d     = S_HI;
                    byte_d      = dbg_byte;
                    out_nib_d   = dbg_byte[7:4];
                    wo_d        = 1'b1;
                    dbg_ready_d = 1'b1;
                    gnt_dbg_d   = 1'b1;
                    last_dbg_d  = 1'b0;
                end else if (take_cpu) begin
                    state_d    = S_HI;
                    byte_d     = cpu_byte;
                    out_nib_d  = cpu_byte[7:4];
                    wo_d       = 1'b1;
                    rd_d       = rd_q + PW'(2);
                    gnt_dbg_d  = 1'b0;
                    last_dbg_d = 1'b1;
                end
            end
            S_HI: begin
                state_d = S_GAP;
                pace_d  = GAP_LD;
            end
            S_GAP: begin
                if (pace_dec == '0) begin
                    state_d   = S_LO;
                    wo_d      = 1'b1;
                    out_nib_d = byte_q[3:0];
                end
            end
            S_LO: begin
                state_d = S_DRAIN;
                pace_d  = GAP_LD;
                drain_d = DRAIN_LD;
            end
            S_DRAIN: begin
                // drain_q holds off busy_s sampling until a busy
                // raised right after the LO write has crossed the
                // synchronizer.
                if (pace_dec == '0 && drain_q == 2'd0 && !busy_s_q) begin
                    state_d   = S_IDLE;
                    gnt_dbg_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge tb04_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_m_q    <= 1'b0;
            busy_s_q    <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            byte_q      <= '0;
            pace_q      <= '0;
            drain_q     <= 2'd0;
            wo_q        <= 1'b0;
            out_nib_q   <= 4'd0;
            dbg_ready_q <= 1'b0;
            gnt_dbg_q   <= 1'b0;
            ovf_q       <= 1'b0;
            last_dbg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_m_q    <= uart_busy;
            busy_s_q    <= busy_m_q;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            byte_q      <= byte_d;
            pace_q      <= pace_d;
            drain_q     <= drain_d;
            wo_q        <= wo_d;
            out_nib_q   <= out_nib_d;
            dbg_ready_q <= dbg_ready_d;
            gnt_dbg_q   <= gnt_dbg_d;
            ovf_q       <= ovf_d;
            last_dbg_q  <= last_dbg_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge tb04_clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= cpu_nib;
        end
    end

    assign wo        = wo_q;
    assign out_nib   = out_nib_q;
    assign dbg_ready = dbg_ready_q;
    assign gnt_dbg   = gnt_dbg_q;
    assign cpu_ovf   = ovf_q;

endmodule
